mac_result_serializer: RTL and testbench
========================================

# mac_result_serializer

Parallel-to-serial unloader for the MAC datapath: accepts one accumulated result word through a valid/ready load port and shifts it out one bit per accepted beat on a serial valid/ready port, marking the final beat. It is the read-out end of the MAC result register chain. It turns the registered accumulator word back into a bit stream for the FPGA pin/link interface.

## Interface
Parameters:
- `WIDTH`, 16: result word width in bits; legal range 2..64.
- `LSB_FIRST`, 1: 1 shifts bit 0 first, 0 shifts bit WIDTH-1 first.

Ports:
- `clk_i` input 1: single clock; all state updates on rising edge.
- `reset_i` input 1: reset, asynchronous, active-high.
- `load_valid_i` input 1: `data_i` holds a word to send.
- `load_ready_o` output 1: serializer can accept a word.
- `data_i` input WIDTH: result word; sampled only on the load handshake.
- `serial_valid_o` output 1: `serial_o` holds a valid beat.
- `serial_ready_i` input 1: downstream accepts the current beat.
- `serial_o` output 1: current serial bit.
- `serial_last_o` output 1: current beat is the last beat of the word.
- `busy_o` output 1: a word is in flight (state is not IDLE).

## Operation
- FSM states: IDLE, SHIFT, and PARITY when the parity feature is compiled in.
- IDLE:
  - `load_ready_o`=1 and `serial_valid_o`=0.
  - The load handshake (`load_valid_i` & `load_ready_o` at a rising edge) copies `data_i` into the shift register and clears the beat counter.
  - The FSM then moves to SHIFT.
- SHIFT:
  - `serial_valid_o`=1, `load_ready_o`=0.
  - `serial_o` = shift register bit 0 when `LSB_FIRST`=1, else bit WIDTH-1.
  - A beat is accepted when `serial_valid_o` & `serial_ready_i` at a rising edge. Each accepted beat shifts the register by one and increments the counter.
  - When `serial_ready_i`=0, `serial_o`, `serial_last_o` and the counter hold unchanged.
- Counter:
  - Width is clog2(WIDTH+1).
  - When counter = WIDTH-1, the current beat is the last data bit.
  - On acceptance of that beat, the FSM goes to PARITY if compiled in, otherwise back to IDLE.
- `serial_last_o` is asserted:
  - on the final data beat when parity is compiled out;
  - only in PARITY when parity is compiled in.
- Loads are never accepted outside IDLE, so no word is dropped or overwritten.
- `load_valid_i` asserted during SHIFT is ignored until IDLE. The word is not sampled early.
- Reset at any time, including mid-word:
  - state goes to IDLE; the shift register and counter are cleared;
  - the partial word is discarded; no `serial_last_o` is emitted for it.

## Timing
- Reset values: `load_ready_o`=1, `serial_valid_o`=0, `serial_o`=0, `serial_last_o`=0, `busy_o`=0.
- Load-to-first-beat latency: 1 cycle. The handshake occurs at edge N, and the first bit is valid after edge N.
- All outputs are registered or decoded from registered state only. There is no combinational path from any input to any output.
- With `serial_ready_i` held at 1:
  - a word occupies WIDTH cycles in SHIFT, plus 1 in PARITY if compiled in;
  - the FSM then spends 1 cycle in IDLE;
  - minimum period per word is therefore WIDTH+1 cycles, or WIDTH+2 with parity.
- When a load and a final-beat acceptance would coincide, the load is not possible because `load_ready_o`=0 in SHIFT. The load takes effect no earlier than the first IDLE cycle.

## Configuration
- Macro: `MAC_SERIALIZER_PARITY_EN`.
- Defined:
  - after the WIDTH data beats, one extra PARITY beat is sent.
  - `serial_o` on that beat = even parity, i.e. the XOR of all WIDTH bits of the loaded word, computed at load time and held in a register.
  - `serial_last_o`=1 only on this beat.
- Undefined: no parity register or PARITY state exists, and the word is exactly WIDTH beats.

## Structure
- Shared package `mac_pkg`:
  - state enumeration `ser_state_t` (IDLE, SHIFT, PARITY);
  - `MAC_RESULT_WIDTH` default constant (16).
- One natural sub-module, `mac_shift_reg`: a WIDTH-bit load/shift register with direction selected by `LSB_FIRST`, using async active-high reset to 0.
- The FSM, counter and parity logic live in the top.

## Test plan
- Reset then idle → `load_ready_o`=1, `serial_valid_o`=0, `serial_o`=0, `busy_o`=0.
- WIDTH=16, `LSB_FIRST`=1, load 16'hA5C3, ready held 1 → bits 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1 on consecutive cycles; `serial_last_o` on beat 16 only; `load_ready_o` returns 1 the next cycle.
- Same word with `LSB_FIRST`=0 → first beat is 1 (bit 15); beat 16 is bit 0 = 1.
- Load 16'h00FF, toggle `serial_ready_i` 1,0,0,1,... → `serial_o` and the counter hold during stalls; exactly 16 accepted beats.
- Assert `reset_i` after beat 5 of 16'hFFFF → outputs return to reset values immediately; the next load of 16'h0001 streams cleanly from bit 0.
- With `MAC_SERIALIZER_PARITY_EN`, load 16'h0007 → 16 data beats, then a parity beat of 1 with `serial_last_o`=1; load 16'h0003 → parity beat 0.

Source files
------------

// File: rtl/mac_pkg.sv
// mac_pkg: shared types and defaults for the MAC result datapath.
// Revision: 1.0
`default_nettype none

package mac_pkg;

  localparam int MAC_RESULT_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } ser_state_t;

endpackage

`default_nettype wire

// File: rtl/mac_shift_reg.sv
// mac_shift_reg: WIDTH-bit load/shift register; LSB_FIRST picks the shift direction.
// Revision: 1.0
`default_nettype none

module mac_shift_reg
  import mac_pkg::*;
#(
  parameter int WIDTH     = MAC_RESULT_WIDTH,
  parameter int LSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] load_data,
  output logic             out_bit
);

  logic [WIDTH-1:0] sreg;
  logic [WIDTH-1:0] shifted;

  generate
    if (LSB_FIRST != 0) begin : g_lsb
      assign shifted = {1'b0, sreg[WIDTH-1:1]};
      assign out_bit = sreg[0];
    end else begin : g_msb
      assign shifted = {sreg[WIDTH-2:0], 1'b0};
      assign out_bit = sreg[WIDTH-1];
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sreg <= '0;
    end else if (load) begin
      sreg <= load_data;
    end else if (shift) begin
      sreg <= shifted;
    end
  end

endmodule

`default_nettype wire

// File: rtl/mac_result_serializer.sv
// mac_result_serializer: valid/ready word load, valid/ready serial bit stream with last-beat flag.
// Optional even-parity trailer beat under MAC_SERIALIZER_PARITY_EN. Revision: 1.0
`default_nettype none

module mac_result_serializer
  import mac_pkg::*;
#(
  parameter int WIDTH     = MAC_RESULT_WIDTH,
  parameter int LSB_FIRST = 1
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             load_valid_i,
  output logic             load_ready_o,
  input  logic [WIDTH-1:0] data_i,
  output logic             serial_valid_o,
  input  logic             serial_ready_i,
  output logic             serial_o,
  output logic             serial_last_o,
  output logic             busy_o
);

  localparam int             CW       = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]  LAST_CNT = CW'(WIDTH - 1);

  ser_state_t    state;
  ser_state_t    state_next;
  logic [CW-1:0] count;
  logic          load;
  logic          shift;
  logic          sr_bit;
  logic          final_data_beat;

  assign load            = (state == IDLE) && load_valid_i;
  assign shift           = (state == SHIFT) && serial_ready_i;
  assign final_data_beat = (state == SHIFT) && (count == LAST_CNT);

  mac_shift_reg #(
    .WIDTH     (WIDTH),
    .LSB_FIRST (LSB_FIRST)
  ) u_shift_reg (
    .clk       (clk_i),
    .rst       (reset_i),
    .load      (load),
    .shift     (shift),
    .load_data (data_i),
    .out_bit   (sr_bit)
  );

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state <= IDLE;
      count <= '0;
    end else begin
      state <= state_next;
      if (load) begin
        count <= '0;
      end else if (shift) begin
        count <= count + CW'(1);
      end
    end
  end

`ifdef MAC_SERIALIZER_PARITY_EN
  logic parity_q;

  // Parity is taken from the loaded word, not from the draining shift register.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      parity_q <= 1'b0;
    end else if (load) begin
      parity_q <= ^data_i;
    end
  end
`endif

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (load_valid_i) state_next = SHIFT;
      end
      SHIFT: begin
        if (serial_ready_i && (count == LAST_CNT)) begin
`ifdef MAC_SERIALIZER_PARITY_EN
          state_next = PARITY;
`else
          state_next = IDLE;
`endif
        end
      end
`ifdef MAC_SERIALIZER_PARITY_EN
      PARITY: begin
        if (serial_ready_i) state_next = IDLE;
      end
`endif
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    serial_o      = 1'b0;
    serial_last_o = 1'b0;
    case (state)
      SHIFT: begin
        serial_o = sr_bit;
`ifndef MAC_SERIALIZER_PARITY_EN
        serial_last_o = final_data_beat;
`endif
      end
`ifdef MAC_SERIALIZER_PARITY_EN
      PARITY: begin
        serial_o      = parity_q;
        serial_last_o = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  assign load_ready_o   = (state == IDLE);
  assign serial_valid_o = (state != IDLE);
  assign busy_o         = (state != IDLE);

`ifdef MAC_SERIALIZER_PARITY_EN
  logic unused_final;
  assign unused_final = final_data_beat;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mac_result_serializer.sv
// Bench for mac_result_serializer: LSB-first and MSB-first instances share stimulus,
// each compared against a word-level bit-sequence model.
`default_nettype none

module tb_mac_result_serializer;

  localparam int W = 16;
`ifdef MAC_SERIALIZER_PARITY_EN
  localparam int NB = W + 1;
`else
  localparam int NB = W;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         load_valid;
  logic [W-1:0] data;
  logic         ser_ready;

  logic lr_l, sv_l, so_l, sl_l, bz_l;
  logic lr_m, sv_m, so_m, sl_m, bz_m;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mac_result_serializer #(.WIDTH(W), .LSB_FIRST(1)) dut_l (
    .clk_i          (clk),
    .reset_i        (rst),
    .load_valid_i   (load_valid),
    .load_ready_o   (lr_l),
    .data_i         (data),
    .serial_valid_o (sv_l),
    .serial_ready_i (ser_ready),
    .serial_o       (so_l),
    .serial_last_o  (sl_l),
    .busy_o         (bz_l)
  );

  mac_result_serializer #(.WIDTH(W), .LSB_FIRST(0)) dut_m (
    .clk_i          (clk),
    .reset_i        (rst),
    .load_valid_i   (load_valid),
    .load_ready_o   (lr_m),
    .data_i         (data),
    .serial_valid_o (sv_m),
    .serial_ready_i (ser_ready),
    .serial_o       (so_m),
    .serial_last_o  (sl_m),
    .busy_o         (bz_m)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // {load_ready, serial_valid, busy, serial, last}
  task automatic chk_idle(input string tag);
    chk({tag, "_lsb"}, {59'd0, lr_l, sv_l, bz_l, so_l, sl_l}, 64'b10000);
    chk({tag, "_msb"}, {59'd0, lr_m, sv_m, bz_m, so_m, sl_m}, 64'b10000);
  endtask

  // mode 0: ready held 1; mode 1: ready pattern 1,0,0,1; mode 2: random ready.
  // abort_at >= 0 asserts reset once that many beats have been accepted.
  task automatic run_word(input logic [W-1:0] w, input int mode, input int abort_at);
    int   idx = 0;
    int   cyc = 0;
    logic exp_l, exp_m, exp_last;
    chk_idle("pre_load");
    load_valid = 1'b1;
    data       = w;
    @(posedge clk); #1;
    while (idx < NB && cyc < 40 * W) begin
      if (idx == abort_at) begin
        rst = 1'b1;
        load_valid = 1'b0;
        #1;
        chk_idle("reset_mid_word");
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        chk_idle("after_reset");
        return;
      end
      case (mode)
        0:       ser_ready = 1'b1;
        1:       ser_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
        default: ser_ready = 1'($urandom_range(0, 1));
      endcase
      load_valid = 1'($urandom_range(0, 1));
      data       = W'($urandom);
      if (idx < W) begin
        exp_l = w[idx];
        exp_m = w[W-1-idx];
      end else begin
        exp_l = ^w;
        exp_m = ^w;
      end
      exp_last = (idx == NB - 1);
      chk("beat_lsb", {59'd0, lr_l, sv_l, bz_l, so_l, sl_l}, {59'd0, 1'b0, 1'b1, 1'b1, exp_l, exp_last});
      chk("beat_msb", {59'd0, lr_m, sv_m, bz_m, so_m, sl_m}, {59'd0, 1'b0, 1'b1, 1'b1, exp_m, exp_last});
      @(posedge clk); #1;
      if (ser_ready) idx++;
      cyc++;
    end
    load_valid = 1'b0;
    ser_ready  = 1'b0;
    chk("beat_count", 64'(idx), 64'(NB));
    chk_idle("post_word");
  endtask

  initial begin
    rst        = 1'b1;
    load_valid = 1'b0;
    data       = '0;
    ser_ready  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_idle("in_reset");
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_idle("reset_idle");

    run_word(16'hA5C3, 0, -1);
    run_word(16'h00FF, 1, -1);
    run_word(16'hFFFF, 0, 5);
    run_word(16'h0001, 0, -1);
    run_word(16'h0007, 0, -1);
    run_word(16'h0003, 2, -1);
    repeat (8) run_word(W'($urandom), 2, -1);
    repeat (2) run_word(W'($urandom), 0, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
